partial_product_generator: RTL and testbench

- Sequential front end of the multiplier datapath.
- Accepts one multiplicand/multiplier pair over a valid/ready handshake.
- Builds the 2^EXPONENT shifted partial products one lane per cycle into a packed output register.
- Presents the packed vector to the balanced adder tree over a second valid/ready handshake. The tree's sum of all lanes, taken mod 2^DATA_WIDTH, equals multiplicand × multiplier mod 2^DATA_WIDTH.

---
 rtl/partial_product_generator_if.sv | 34 +++
 rtl/partial_product_generator.sv | 120 ++++++++++++
 tb/tb_partial_product_generator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/partial_product_generator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : partial_product_generator_if                                  |
// | Purpose  : Operand input and packed-lane output valid/ready handshakes   |
// |            of the partial product generator.                             |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
interface partial_product_generator_if #(
   parameter int EXPONENT   = 2,
   parameter int DATA_WIDTH = 8
);
   localparam int c_N = 1 << EXPONENT;

   logic                      inValid;
   logic                      inReady;
   logic [DATA_WIDTH-1:0]     multiplicand;
   logic [c_N-1:0]            multiplier;
   logic                      outValid;
   logic                      outReady;
   logic [c_N*DATA_WIDTH-1:0] partialProducts;

   // Producer / consumer side
   modport master (
      output inValid, multiplicand, multiplier, outReady,
      input  inReady, outValid, partialProducts
   );

   // Generator side
   modport slave (
      input  inValid, multiplicand, multiplier, outReady,
      output inReady, outValid, partialProducts
   );
endinterface
`default_nettype wire

// File: rtl/partial_product_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : partial_product_generator                                     |
// | Purpose  : Captures a multiplicand/multiplier pair and builds the        |
// |            2^EXPONENT shifted partial products one lane per cycle, then  |
// |            presents the packed vector to the adder tree.                 |
// | Options  : PPG_SKIP_ZERO_EN - visit only lanes whose multiplier bit is   |
// |            set (priority-encoded), shortening BUILD.                     |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module partial_product_generator #(
   parameter int EXPONENT   = 2,
   parameter int DATA_WIDTH = 8
) (
   input  wire logic                    clock,
   input  wire logic                    reset,
   partial_product_generator_if.slave   bus
);
   localparam int                  c_N    = 1 << EXPONENT;
   localparam logic [EXPONENT-1:0] c_LAST = EXPONENT'(c_N - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUILD   = 2'd1,
      S_PRESENT = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [DATA_WIDTH-1:0]     r_mcand;
   logic [c_N-1:0]            r_mplr;
   logic [EXPONENT-1:0]       r_cnt;
   logic [c_N*DATA_WIDTH-1:0] r_pp;

   logic                      w_accept;
   logic                      w_last;
   logic                      w_start_present;
   logic [EXPONENT-1:0]       w_start_idx;
   logic [EXPONENT-1:0]       w_next_idx;
   logic [DATA_WIDTH-1:0]     w_lane;

   assign w_accept = (r_state == S_IDLE) && bus.inValid;

   // Lane value for the lane currently addressed; the shift truncates to lane width
   assign w_lane = r_mplr[r_cnt] ? (r_mcand << r_cnt) : '0;

`ifdef PPG_SKIP_ZERO_EN
   logic [c_N-1:0] w_above;

   // Index of the lowest set bit; callers guard the all-zero case themselves
   function automatic logic [EXPONENT-1:0] f_lowest(input logic [c_N-1:0] mask);
      logic [EXPONENT-1:0] idx;
      idx = '0;
      for (int i = c_N - 1; i >= 0; i--) begin
         if (mask[i]) idx = EXPONENT'(i);
      end
      return idx;
   endfunction

   // Multiplier bits strictly above the lane being written are still to visit
   always_comb begin
      w_above = '0;
      for (int i = 0; i < c_N; i++) begin
         w_above[i] = r_mplr[i] && (EXPONENT'(i) > r_cnt);
      end
   end

   assign w_last          = ~|w_above;
   assign w_next_idx      = f_lowest(w_above);
   assign w_start_idx     = f_lowest(bus.multiplier);
   assign w_start_present = (bus.multiplier == '0);
`else
   assign w_last          = (r_cnt == c_LAST);
   assign w_next_idx      = r_cnt + 1'b1;
   assign w_start_idx     = '0;
   assign w_start_present = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (bus.inValid) w_state_nxt = w_start_present ? S_PRESENT : S_BUILD;
         S_BUILD:   if (w_last)      w_state_nxt = S_PRESENT;
         S_PRESENT: if (bus.outReady) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, lane counter and packed lane register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mcand <= '0;
         r_mplr  <= '0;
         r_cnt   <= '0;
         r_pp    <= '0;
      end else if (w_accept) begin
         r_mcand <= bus.multiplicand;
         r_mplr  <= bus.multiplier;
         r_cnt   <= w_start_idx;
         r_pp    <= '0;
      end else if (r_state == S_BUILD) begin
         r_pp[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= w_lane;
         r_cnt                                <= w_next_idx;
      end
   end

   // Handshake outputs come straight from the state register
   assign bus.inReady         = (r_state == S_IDLE);
   assign bus.outValid        = (r_state == S_PRESENT);
   assign bus.partialProducts = r_pp;

endmodule
`default_nettype wire

// File: tb/tb_partial_product_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_partial_product_generator                                  |
// | Purpose  : Self-checking bench for partial_product_generator against an  |
// |            arithmetic reference model.                                   |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module tb_partial_product_generator;
   localparam int c_E  = 2;
   localparam int c_DW = 8;
   localparam int c_N  = 1 << c_E;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_err;

   partial_product_generator_if #(.EXPONENT(c_E), .DATA_WIDTH(c_DW)) bus ();

   partial_product_generator #(.EXPONENT(c_E), .DATA_WIDTH(c_DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: lane i = multiplier bit i ? multiplicand*2^i mod 2^DW : 0
   function automatic logic [c_N*c_DW-1:0] model_pp(input int mc, input int mp);
      logic [c_N*c_DW-1:0] v;
      v = '0;
      for (int i = 0; i < c_N; i++) begin
         if ((mp >> i) % 2 == 1)
            v = v | ((c_N*c_DW)'((mc * (2 ** i)) % (2 ** c_DW)) << (i * c_DW));
      end
      return v;
   endfunction

   // Reference: edges from accept until PRESENT is entered
   function automatic int model_lat(input int mp);
`ifdef PPG_SKIP_ZERO_EN
      int pc;
      pc = 0;
      for (int i = 0; i < c_N; i++) pc += (mp >> i) % 2;
      return pc;
`else
      return c_N;
`endif
   endfunction

   function automatic int lane_sum(input logic [c_N*c_DW-1:0] v);
      int s;
      s = 0;
      for (int i = 0; i < c_N; i++) s += int'(v[i*c_DW +: c_DW]);
      return s % (2 ** c_DW);
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!bus.inReady && w < 50) begin
         step();
         w++;
      end
      chk("inReady_idle", 64'(bus.inReady), 64'd1);
   endtask

   task automatic run_txn(input logic [7:0] mc, input logic [3:0] mp, input int hold);
      int                  lat;
      logic [c_N*c_DW-1:0] exp_v;
      exp_v = model_pp(int'(mc), int'(mp));
      wait_ready();
      bus.multiplicand = mc;
      bus.multiplier   = mp;
      bus.inValid      = 1'b1;
      bus.outReady     = 1'b0;
      step();
      bus.multiplicand = 8'($urandom);
      bus.multiplier   = 4'($urandom);
      bus.inValid      = 1'b0;
      chk("inReady_busy", 64'(bus.inReady), 64'd0);
      chk("cleared_at_accept", 64'(bus.partialProducts), 64'd0);
      lat = 0;
      while (!bus.outValid && lat < 50) begin
         bus.inValid = 1'($urandom_range(0, 1));
         step();
         lat++;
      end
      bus.inValid = 1'b0;
      chk("latency", 64'(lat), 64'(model_lat(int'(mp))));
      chk("vector", 64'(bus.partialProducts), 64'(exp_v));
      chk("lane_sum", 64'(lane_sum(bus.partialProducts)), 64'((int'(mc) * int'(mp)) % 256));
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_valid", 64'(bus.outValid), 64'd1);
         chk("hold_ready", 64'(bus.inReady), 64'd0);
         chk("hold_vector", 64'(bus.partialProducts), 64'(exp_v));
      end
      bus.outReady = 1'b1;
      step();
      bus.outReady = 1'b0;
      chk("post_inReady", 64'(bus.inReady), 64'd1);
      chk("post_outValid", 64'(bus.outValid), 64'd0);
      chk("post_vector_kept", 64'(bus.partialProducts), 64'(exp_v));
   endtask

   initial begin
      int lat;
      n_vec = 0;
      n_err = 0;
      reset            = 1'b1;
      bus.inValid      = 1'b0;
      bus.outReady     = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      step();
      step();
      chk("rst_inReady", 64'(bus.inReady), 64'd1);
      chk("rst_outValid", 64'(bus.outValid), 64'd0);
      chk("rst_vector", 64'(bus.partialProducts), 64'd0);
      reset = 1'b0;
      step();

      // Directed cases
      run_txn(8'h05, 4'b1011, 0);
      run_txn(8'hFF, 4'b1111, 0);
      run_txn(8'h05, 4'b1000, 0);
      run_txn(8'h05, 4'b0000, 0);
      run_txn(8'h5A, 4'b0110, 10);

      // Back-to-back with inValid held high and outReady tied high
      wait_ready();
      bus.outReady     = 1'b1;
      bus.multiplicand = 8'h05;
      bus.multiplier   = 4'b1011;
      bus.inValid      = 1'b1;
      step();
      bus.multiplicand = 8'h03;
      bus.multiplier   = 4'b0001;
      lat = 0;
      while (!bus.outValid && lat < 50) begin step(); lat++; end
      chk("b2b_first_vector", 64'(bus.partialProducts), 64'h28000A05);
      step();
      chk("b2b_idle_ready", 64'(bus.inReady), 64'd1);
      step();
      bus.inValid = 1'b0;
      lat = 0;
      while (!bus.outValid && lat < 50) begin step(); lat++; end
      chk("b2b_second_lat", 64'(lat), 64'(model_lat(1)));
      chk("b2b_second_vector", 64'(bus.partialProducts), 64'h00000003);
      step();
      bus.outReady = 1'b0;
      chk("b2b_done_ready", 64'(bus.inReady), 64'd1);

      // Reset in the middle of BUILD
      wait_ready();
      bus.multiplicand = 8'h05;
      bus.multiplier   = 4'b1011;
      bus.inValid      = 1'b1;
      step();
      bus.inValid = 1'b0;
      step();
      step();
      chk("mid_build_lanes", 64'(bus.partialProducts), 64'h00000A05);
      reset = 1'b1;
      #1;
      chk("mid_rst_outValid", 64'(bus.outValid), 64'd0);
      chk("mid_rst_vector", 64'(bus.partialProducts), 64'd0);
      chk("mid_rst_inReady", 64'(bus.inReady), 64'd1);
      #2;
      reset        = 1'b0;
      bus.outReady = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("abandoned_quiet", 64'(bus.outValid), 64'd0);
      end
      bus.outReady = 1'b0;

      // Randomised transactions
      for (int t = 0; t < 30; t++) begin
         run_txn(8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
